// File: rtl/airlock_input_conditioner_pkg.sv
// airlock_pkg: shared constants and types for the airlock input front end.
package airlock_pkg;

    localparam logic SW_IDLE  = 1'b0;
    localparam logic KEY_IDLE = 1'b1;

    localparam int DEBOUNCE_DEFAULT = 4;

    localparam int SW_ARRIVE = 0;
    localparam int SW_DEPART = 1;
    localparam int SW_OUTER  = 2;
    localparam int SW_INNER  = 3;
    localparam int KEY_RESET = 0;
    localparam int KEY_FP    = 1;
    localparam int KEY_EV    = 2;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } chan_t;

endpackage

// File: rtl/airlock_input_conditioner_if.sv
// airlock_input_conditioner_if: raw pads in, conditioned levels and pulses out.
interface airlock_input_conditioner_if #(
    parameter int N_SW  = 4,
    parameter int N_KEY = 3
);
    logic [N_SW-1:0]  sw_raw;
    logic [N_KEY-1:0] key_raw;
    logic [N_SW-1:0]  sw_level;
    logic [N_SW-1:0]  sw_change;
    logic [N_KEY-1:0] key_held;
    logic [N_KEY-1:0] key_press;
    logic [N_KEY-1:0] key_release;

    modport slave (
        input  sw_raw, key_raw,
        output sw_level, sw_change, key_held, key_press, key_release
    );

    modport master (
        output sw_raw, key_raw,
        input  sw_level, sw_change, key_held, key_press, key_release
    );
endinterface

// File: rtl/airlock_input_conditioner_debounce.sv
// debounce_channel: two-flop synchroniser, counting debouncer and registered edge pulses.
module debounce_channel
    import airlock_pkg::*;
#(
    parameter logic IDLE            = 1'b0,
    parameter logic INVERT          = 1'b0,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic Clock,
    input  logic Reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'((DEBOUNCE_CYCLES < 1) ? 0 : DEBOUNCE_CYCLES - 1);

    logic meta_q, sync_q;
    logic stable_q, stable_d;
    logic rise_q, rise_d, fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic sync_in, accept;

    // cnt is cleared on acceptance, so it never exceeds LAST and cannot wrap
    always_comb begin
        sync_in  = sync_q ^ INVERT;
        accept   = (sync_in != stable_q) && (cnt_q == LAST);
        stable_d = accept ? ~stable_q : stable_q;
        cnt_d    = (sync_in == stable_q || accept) ? '0 : cnt_q + CW'(1);
        rise_d   = accept & ~stable_q;
        fall_d   = accept & stable_q;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            meta_q   <= IDLE;
            sync_q   <= IDLE;
            stable_q <= IDLE ^ INVERT;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            meta_q   <= raw;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign level = stable_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
endmodule

// File: rtl/airlock_input_conditioner.sv
// airlock_input_conditioner: per-channel sync/debounce/edge-detect of switch and key pads.
module airlock_input_conditioner
    import airlock_pkg::*;
#(
    parameter int N_SW            = 4,
    parameter int N_KEY           = 3,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input logic Clock,
    input logic Reset,
    airlock_input_conditioner_if.slave bus
);
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_cfg_err
        $error("airlock_input_conditioner: DEBOUNCE_CYCLES must be in 1..255");
    end

    chan_t sw_ch  [N_SW];
    chan_t key_ch [N_KEY];

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_channel #(
            .IDLE(SW_IDLE),
            .INVERT(1'b0),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .Clock(Clock),
            .Reset(Reset),
            .raw(bus.sw_raw[i]),
            .level(sw_ch[i].level),
            .rise(sw_ch[i].rise),
            .fall(sw_ch[i].fall)
        );
        assign bus.sw_level[i]  = sw_ch[i].level;
        assign bus.sw_change[i] = sw_ch[i].rise | sw_ch[i].fall;
    end

    // keys are active-low at the pad; the channel inverts so held means pressed
    for (genvar i = 0; i < N_KEY; i++) begin : g_key
        debounce_channel #(
            .IDLE(KEY_IDLE),
            .INVERT(1'b1),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .Clock(Clock),
            .Reset(Reset),
            .raw(bus.key_raw[i]),
            .level(key_ch[i].level),
            .rise(key_ch[i].rise),
            .fall(key_ch[i].fall)
        );
        assign bus.key_held[i]    = key_ch[i].level;
        assign bus.key_press[i]   = key_ch[i].rise;
        assign bus.key_release[i] = key_ch[i].fall;
    end
endmodule

// File: tb/tb_airlock_input_conditioner.sv
// tb_airlock_input_conditioner: directed steps with a pulse scoreboard for the input conditioner.
module tb_airlock_input_conditioner;
    typedef struct packed {
        int         c;
        logic [3:0] sw;
        logic [2:0] kp;
        logic [2:0] kr;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    ev_t  sb[$];

    airlock_input_conditioner_if #(.N_SW(4), .N_KEY(3)) bus();

    airlock_input_conditioner #(
        .N_SW(4),
        .N_KEY(3),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .Clock(clk),
        .Reset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // pulse expected d clock edges after inputs applied just after a falling edge
    task automatic expect_pulse(input int d, input logic [3:0] sw, input logic [2:0] kp, input logic [2:0] kr);
        ev_t t;
        t.c  = cyc + d;
        t.sw = sw;
        t.kp = kp;
        t.kr = kr;
        sb.push_back(t);
    endtask

    task automatic step(input int n);
        ev_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (|{bus.sw_change, bus.key_press, bus.key_release}) begin
                if (sb.size() == 0)
                    chk("unexpected_pulse", 32'({bus.sw_change, bus.key_press, bus.key_release}), 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("pulse_cycle", 32'(cyc), 32'(e.c));
                    chk("sw_change", 32'(bus.sw_change), 32'(e.sw));
                    chk("key_press", 32'(bus.key_press), 32'(e.kp));
                    chk("key_release", 32'(bus.key_release), 32'(e.kr));
                end
            end else if (sb.size() != 0 && sb[0].c < cyc) begin
                e = sb.pop_front();
                chk("missing_pulse", 32'(cyc), 32'(e.c));
            end
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_sw_level"}, 32'(bus.sw_level), 32'd0);
        chk({tag, "_sw_change"}, 32'(bus.sw_change), 32'd0);
        chk({tag, "_key_held"}, 32'(bus.key_held), 32'd0);
        chk({tag, "_key_press"}, 32'(bus.key_press), 32'd0);
        chk({tag, "_key_release"}, 32'(bus.key_release), 32'd0);
    endtask

    initial begin
        bus.sw_raw  = 4'b0000;
        bus.key_raw = 3'b111;
        step(2);
        chk_idle_outputs("in_reset");
        rst = 1'b0;
        step(50);
        chk_idle_outputs("idle_50");

        // switch 2 up, then down: one pulse each way after 6 edges
        bus.sw_raw[2] = 1'b1;
        expect_pulse(6, 4'b0100, 3'b000, 3'b000);
        step(4);
        chk("sw2_not_yet", 32'(bus.sw_level), 32'd0);
        step(2);
        chk("sw2_up", 32'(bus.sw_level), 32'b0100);
        step(10);
        bus.sw_raw[2] = 1'b0;
        expect_pulse(6, 4'b0100, 3'b000, 3'b000);
        step(10);
        chk("sw2_down", 32'(bus.sw_level), 32'd0);

        // key 1 bounces with 2-cycle gaps, then holds pressed
        bus.key_raw = 3'b101;
        step(2);
        bus.key_raw = 3'b111;
        step(2);
        bus.key_raw = 3'b101;
        expect_pulse(6, 4'b0000, 3'b010, 3'b000);
        step(10);
        chk("key1_held", 32'(bus.key_held), 32'b010);
        bus.key_raw = 3'b111;
        expect_pulse(6, 4'b0000, 3'b000, 3'b010);
        step(10);
        chk("key1_released", 32'(bus.key_held), 32'd0);

        // key 2 low for only 3 cycles: rejected as a glitch
        bus.key_raw = 3'b011;
        step(3);
        bus.key_raw = 3'b111;
        step(15);
        chk("key2_glitch", 32'(bus.key_held), 32'd0);

        // simultaneous switch 0 and key 1 changes
        bus.sw_raw[0] = 1'b1;
        bus.key_raw   = 3'b101;
        expect_pulse(6, 4'b0001, 3'b010, 3'b000);
        step(10);
        chk("simul_sw", 32'(bus.sw_level), 32'b0001);
        chk("simul_key", 32'(bus.key_held), 32'b010);
        bus.sw_raw[0] = 1'b0;
        bus.key_raw   = 3'b111;
        expect_pulse(6, 4'b0001, 3'b000, 3'b010);
        step(10);
        chk("simul_back_sw", 32'(bus.sw_level), 32'd0);
        chk("simul_back_key", 32'(bus.key_held), 32'd0);

        // switch 1 up so reset has a level to clear
        bus.sw_raw[1] = 1'b1;
        expect_pulse(6, 4'b0010, 3'b000, 3'b000);
        step(10);
        chk("sw1_up", 32'(bus.sw_level), 32'b0010);

        // switch 3 up, reset while its count is at 2
        bus.sw_raw[3] = 1'b1;
        step(4);
        rst = 1'b1;
        #1;
        chk_idle_outputs("mid_reset");
        step(1);
        rst = 1'b0;
        expect_pulse(6, 4'b1010, 3'b000, 3'b000);
        step(12);
        chk("after_reset_level", 32'(bus.sw_level), 32'b1010);
        step(20);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
